gpu_line_fifo: RTL



---
 rtl/gpu_line_fifo_pkg.sv | 21 ++
 rtl/gpu_line_fifo_mem.sv | 38 +++
 rtl/gpu_line_fifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gpu_line_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_line_fifo_pkg
//  Description : Shared constants and types for the per-layer line FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_line_fifo_pkg;

  localparam int NUM_SLOTS        = 4;
  localparam int PIX_BITS_DEFAULT = 8;
  localparam int COL_BITS_DEFAULT = 8;

  typedef logic [1:0] slot_t;
  typedef logic [1:0] credit_t;

  // First line of a frame lands in the muxer's middle-line slot
  localparam slot_t   FIRST_SLOT = 2'd2;
  localparam credit_t CREDIT_MAX = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gpu_line_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dc_1024x8r
//  Description : Simple dual-port RAM, one write port and one read port on the
//                same clock, registered read, read-before-write on collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dc_1024x8r #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);

  logic [DATA_BITS-1:0] r_mem [0:(1<<ADDR_BITS)-1];
  logic [DATA_BITS-1:0] r_rdata;

  // Write port and registered read; non-blocking update gives old data on a
  // same-address collision
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/gpu_line_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_line_fifo
//  Description : Four-line per-layer video buffer. The renderer writes whole
//                lines ahead of the beam; a credit counter keeps the three
//                lines Scale2X reads intact while the next one is written.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_line_fifo
  import gpu_line_fifo_pkg::*;
#(
  parameter int PIX_BITS = PIX_BITS_DEFAULT,
  parameter int COL_BITS = COL_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_lin_sof,
  input  logic                i_lin_wr,
  input  logic [PIX_BITS-1:0] i_lin_wdata,
  input  logic                i_lin_eol,
  output logic                o_lin_rdy,
  input  logic                i_bus_eol,
  input  logic                i_bus_eof,
  input  logic [1:0]          i_vid_line,
  input  logic                i_rd_read,
  input  logic                i_rd_next,
  output logic [PIX_BITS-1:0] o_rd_data,
  output logic                o_rd_vld,
  output logic                o_underrun
);

  localparam int ADDR_BITS = COL_BITS + 2;

  slot_t               r_wr_slot;
  logic [COL_BITS-1:0] r_wr_col;
  logic [COL_BITS-1:0] r_rd_col;
  credit_t             r_credit;
  logic                r_rd_vld;
  logic                r_underrun;

  logic                w_wr_ok;
  logic                w_eol_ok;
  logic                w_line_end;
  logic [PIX_BITS-1:0] w_ram_q;

  // Start of frame overrides any write or line close in the same cycle
  assign o_lin_rdy = (r_credit != CREDIT_MAX);
  assign w_wr_ok   = i_lin_wr  & o_lin_rdy & ~i_lin_sof;
  assign w_eol_ok  = i_lin_eol & o_lin_rdy & ~i_lin_sof;

  // End of frame always arrives with end of line and adds nothing here
  assign w_line_end = i_bus_eol | (i_bus_eol & i_bus_eof);

  mem_dc_1024x8r #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (PIX_BITS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr ({r_wr_slot, r_wr_col}),
    .i_wdata (i_lin_wdata),
    .i_re    (i_rd_read),
    .i_raddr ({i_vid_line, r_rd_col}),
    .o_rdata (w_ram_q)
  );

  // Write pointers: column advances per pixel, slot advances per closed line
  always_ff @(posedge clk) begin
    if (rst || i_lin_sof) begin
      r_wr_slot <= FIRST_SLOT;
      r_wr_col  <= '0;
    end else if (w_eol_ok) begin
      r_wr_slot <= r_wr_slot + 2'd1;
      r_wr_col  <= '0;
    end else if (w_wr_ok) begin
      r_wr_col  <= r_wr_col + COL_BITS'(1);
    end
  end

  // Credit counts completed lines the beam has not yet retired
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit   <= '0;
      r_underrun <= 1'b0;
    end else if (i_lin_sof) begin
      r_credit   <= '0;
    end else begin
      case ({w_eol_ok, w_line_end})
        2'b10: r_credit <= r_credit + 2'd1;
        2'b01: begin
          if (r_credit == '0) begin
            r_underrun <= 1'b1;
          end else begin
            r_credit <= r_credit - 2'd1;
          end
        end
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Read column and response-valid; line end rewinds ahead of rd_next
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_col <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= i_rd_read;
      if (w_line_end) begin
        r_rd_col <= '0;
      end else if (i_rd_next) begin
        r_rd_col <= r_rd_col + COL_BITS'(1);
      end
    end
  end

  // Zero the data when idle so the muxer can OR all layers together
  assign o_rd_data  = r_rd_vld ? w_ram_q : '0;
  assign o_rd_vld   = r_rd_vld;
  assign o_underrun = r_underrun;

endmodule
`default_nettype wire
